// File: rtl/conv_tile_sequencer_pkg.sv
// conv_pkg: shared state encoding, operand counts and packing helpers for the
// 3x3 convolution tile sequencer.
package conv_pkg;

    localparam int N_FILT = 9;
    localparam int N_TILE = 16;
    localparam int N_OUT  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_CLEAR,
        S_RUN,
        S_DONE
    } seq_state_e;

    // Element position inside the packed input tile (4x4, row-major).
    function automatic int idx_i(input int r, input int c);
        return 4 * r + c;
    endfunction

    // Element position inside the packed filter (3x3, row-major).
    function automatic int idx_f(input int r, input int c);
        return 3 * r + c;
    endfunction

    // Element position inside the packed result (2x2, row-major).
    function automatic int idx_o(input int r, input int c);
        return 2 * r + c;
    endfunction

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Tile-buffer read port and host result handshake of the tile sequencer.
// master = sequencer side, slave = buffer/host side.
interface conv_tile_sequencer_if
    import conv_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ADDR_W = 8
);
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DW-1:0]         mem_rd_data;
    logic [N_OUT*DW-1:0]   res;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output mem_rd_en, mem_addr, res, res_valid,
        input  mem_rd_data, res_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, res, res_valid,
        output mem_rd_data, res_ready
    );
endinterface

// File: rtl/conv_tile_sequencer_fetch.sv
// tile_fetch_unit: issues the 25 buffer reads of a job (9 filter words, then
// 16 tile words), aligns the one-cycle read return and holds the operands.
module tile_fetch_unit
    import conv_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   launch_i,
    input  logic                   load_i,
    input  logic [ADDR_W-1:0]      f_base_i,
    input  logic [ADDR_W-1:0]      i_base_i,
    input  logic [DW-1:0]          rd_data_i,
    output logic                   rd_en_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [N_FILT*DW-1:0]   arr_f_o,
    output logic [N_TILE*DW-1:0]   arr_i_o,
    output logic                   fetch_done_o
);

    localparam logic [4:0] K_FILT = 5'(N_FILT);
    localparam logic [4:0] K_LAST = 5'(N_FILT + N_TILE - 1);

    logic [ADDR_W-1:0] f_base_q;
    logic [ADDR_W-1:0] i_base_q;
    logic [4:0]        k_q;
    logic              rd_vld_q;
    logic [4:0]        rd_idx_q;
    logic [DW-1:0]     f_q [N_FILT];
    logic [DW-1:0]     i_q [N_TILE];

    // Base latch, read index, return alignment and operand register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_base_q <= '0;
            i_base_q <= '0;
            k_q      <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            for (int k = 0; k < N_FILT; k++) f_q[k] <= '0;
            for (int k = 0; k < N_TILE; k++) i_q[k] <= '0;
        end else begin
            if (launch_i) begin
                f_base_q <= f_base_i;
                i_base_q <= i_base_i;
            end
            k_q      <= load_i ? k_q + 5'd1 : '0;
            rd_vld_q <= load_i;
            rd_idx_q <= k_q;
            for (int k = 0; k < N_FILT; k++)
                if (rd_vld_q && rd_idx_q == 5'(k)) f_q[k] <= rd_data_i;
            for (int k = 0; k < N_TILE; k++)
                if (rd_vld_q && rd_idx_q == 5'(k + N_FILT)) i_q[k] <= rd_data_i;
        end
    end

    // Read strobe and wrapping address; idle address parks at zero.
    always_comb begin
        rd_en_o      = load_i;
        addr_o       = '0;
        fetch_done_o = load_i && (k_q == K_LAST);
        if (load_i) begin
            if (k_q < K_FILT) addr_o = f_base_q + ADDR_W'(k_q);
            else              addr_o = i_base_q + ADDR_W'(k_q - K_FILT);
        end
    end

    // Flatten the register file onto the array operand buses.
    always_comb begin
        arr_f_o = '0;
        arr_i_o = '0;
        for (int k = 0; k < N_FILT; k++) arr_f_o[DW*k +: DW] = f_q[k];
        for (int k = 0; k < N_TILE; k++) arr_i_o[DW*k +: DW] = i_q[k];
    end

endmodule

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: loads one filter and input tile, clears and runs the
// systolic array for a fixed latency, then hands the 2x2 result to the host.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | array held in reset, waiting for start
//   S_LOAD  | 25 buffer reads (filter then tile)
//   S_DRAIN | last read word returns, no new read
//   S_CLEAR | array reset held CLR_CYCLES with operands stable
//   S_RUN   | array released for ARRAY_LATENCY cycles, capture at end
//   S_DONE  | result valid, waiting for res_ready
module conv_tile_sequencer
    import conv_pkg::*;
#(
    parameter int DW            = 8,
    parameter int ADDR_W        = 8,
    parameter int ARRAY_LATENCY = 12,
    parameter int CLR_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     f_base,
    input  logic [ADDR_W-1:0]     i_base,
    output logic                  busy,
    output logic                  arr_rst,
    output logic [N_TILE*DW-1:0]  arr_i,
    output logic [N_FILT*DW-1:0]  arr_f,
    input  logic [N_OUT*DW-1:0]   arr_o,
    conv_tile_sequencer_if.master bus
);

    localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] RUN_LAST = 8'(ARRAY_LATENCY - 1);

    seq_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [N_OUT*DW-1:0]  res_q, res_d;
    logic                 res_valid_q, res_valid_d;
    logic                 launch;
    logic                 load;
    logic                 fetch_done;

    tile_fetch_unit #(
        .DW     (DW),
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk          (clk),
        .rst          (rst),
        .launch_i     (launch),
        .load_i       (load),
        .f_base_i     (f_base),
        .i_base_i     (i_base),
        .rd_data_i    (bus.mem_rd_data),
        .rd_en_o      (bus.mem_rd_en),
        .addr_o       (bus.mem_addr),
        .arr_f_o      (arr_f),
        .arr_i_o      (arr_i),
        .fetch_done_o (fetch_done)
    );

    // State, phase timer and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state logic; CLEAR and RUN share one down-counter ending at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        launch      = 1'b0;
        load        = (state_q == S_LOAD);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (fetch_done) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d   = CLR_LAST;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = RUN_LAST;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == 8'd0) begin
                    res_d       = arr_o;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign arr_rst       = !((state_q == S_RUN) || (state_q == S_DONE));
    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Self-checking bench for conv_tile_sequencer: behavioural buffer, behavioural
// 3x3 array, directed scenarios and randomized jobs.
module tb_conv_tile_sequencer;
    import conv_pkg::*;

    localparam int DW      = 8;
    localparam int ADDR_W  = 8;
    localparam int LAT     = 12;
    localparam int CLR     = 2;
    localparam int EXP_LAT = 26 + CLR + LAT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   f_base = 8'h00;
    logic [7:0]   i_base = 8'h00;
    logic         busy;
    logic         arr_rst;
    logic [127:0] arr_i;
    logic [71:0]  arr_f;
    logic [31:0]  arr_o;

    conv_tile_sequencer_if #(.DW(DW), .ADDR_W(ADDR_W)) bus ();

    conv_tile_sequencer #(
        .DW            (DW),
        .ADDR_W        (ADDR_W),
        .ARRAY_LATENCY (LAT),
        .CLR_CYCLES    (CLR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .f_base  (f_base),
        .i_base  (i_base),
        .busy    (busy),
        .arr_rst (arr_rst),
        .arr_i   (arr_i),
        .arr_f   (arr_f),
        .arr_o   (arr_o),
        .bus     (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] addr_q [$];
    int         run_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // Tile buffer: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        else               bus.mem_rd_data <= 8'($urandom);
    end

    // Array model: outputs become the 2x2 valid correlation LAT cycles after release.
    always @(posedge clk) begin
        if (arr_rst)            run_cnt <= 0;
        else if (run_cnt < 1000) run_cnt <= run_cnt + 1;
    end

    function automatic logic [31:0] conv(input logic [127:0] t, input logic [71:0] f);
        logic [31:0] o;
        logic [7:0]  acc;
        o = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                acc = 8'd0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        acc = acc + f[8*idx_f(a, b) +: 8] * t[8*idx_i(r + a, c + b) +: 8];
                o[8*idx_o(r, c) +: 8] = acc;
            end
        return o;
    endfunction

    assign arr_o = (!arr_rst && run_cnt >= LAT - 1) ? conv(arr_i, arr_f) : 32'hEEEE_EEEE;

    always @(negedge clk) if (bus.mem_rd_en) addr_q.push_back(bus.mem_addr);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_filt(input logic [7:0] fb);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*idx_f(r, c) +: 8] = mem[fb + 8'(3*r + c)];
        return v;
    endfunction

    function automatic logic [127:0] exp_tile(input logic [7:0] ib);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[8*idx_i(r, c) +: 8] = mem[ib + 8'(4*r + c)];
        return v;
    endfunction

    task automatic fill(input logic [7:0] fb, input logic [7:0] ib);
        for (int k = 0; k < 9; k++)  mem[fb + 8'(k)] = 8'($urandom);
        for (int k = 0; k < 16; k++) mem[ib + 8'(k)] = 8'($urandom);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the sampling edge.
    task automatic launch(input logic [7:0] fb, input logic [7:0] ib, input bit ready_early);
        addr_q.delete();
        f_base = fb;
        i_base = ib;
        start  = 1'b1;
        bus.res_ready = ready_early;
        @(posedge clk);
        #1;
        start  = 1'b0;
        f_base = 8'($urandom);
        i_base = 8'($urandom);
    endtask

    // Follows one job from its sampling edge through the result handshake.
    task automatic complete(input logic [7:0] fb, input logic [7:0] ib,
                            input int hold_cycles, input bit poke);
        int           n;
        logic [71:0]  ef;
        logic [127:0] et;
        logic [31:0]  er;
        logic [7:0]   ea;
        ef = exp_filt(fb);
        et = exp_tile(ib);
        er = conv(et, ef);
        n  = 0;
        while (bus.res_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, EXP_LAT);
        chk("n_reads", addr_q.size(), 25);
        for (int k = 0; k < 25; k++) begin
            ea = (k < 9) ? fb + 8'(k) : ib + 8'(k - 9);
            if (k < addr_q.size()) chk($sformatf("addr[%0d]", k), addr_q[k], ea);
        end
        chk("arr_f", arr_f, ef);
        chk("arr_i", arr_i, et);
        chk("res", bus.res, er);
        for (int c = 0; c < hold_cycles; c++) begin
            if (poke && c == hold_cycles / 2) start = 1'b1;
            @(posedge clk);
            #1;
            if (poke) start = 1'b0;
            chk("hold_valid", bus.res_valid, 1'b1);
            chk("hold_res", bus.res, er);
            chk("hold_ops", {arr_i, arr_f}, {et, ef});
            chk("hold_busy", busy, 1'b1);
            chk("hold_no_read", bus.mem_rd_en, 1'b0);
        end
        bus.res_ready = 1'b1;
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        if (poke) start = 1'b0;
        chk("idle_after_hs", busy, 1'b0);
        chk("valid_after_hs", bus.res_valid, 1'b0);
        chk("res_kept", bus.res, er);
        if (poke) begin
            @(posedge clk);
            #1;
            chk("hs_start_ignored", busy, 1'b0);
        end
        addr_q.delete();
    endtask

    initial begin
        logic [7:0] gf [9];
        logic [7:0] gt [16];
        logic [7:0] fb, ib;
        int         hold;
        bit         early;

        gf = '{8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};
        gt = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
               8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9};
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        bus.res_ready = 1'b0;

        // Reset state
        #1 rst = 1'b0;
        #20;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", bus.mem_rd_en, 1'b0);
        chk("rst_addr", bus.mem_addr, 8'h00);
        chk("rst_arr_rst", arr_rst, 1'b1);
        chk("rst_arr_i", arr_i, '0);
        chk("rst_arr_f", arr_f, '0);
        chk("rst_res", bus.res, '0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Golden tile from the reference data set
        for (int k = 0; k < 9; k++)  mem[8'h10 + k] = gf[k];
        for (int k = 0; k < 16; k++) mem[8'h40 + k] = gt[k];
        launch(8'h10, 8'h40, 1'b0);
        complete(8'h10, 8'h40, 0, 1'b0);
        chk("golden_res", bus.res, 32'h3B22_4A43);

        // Back-pressure with an ignored start pulse
        fill(8'h80, 8'h20);
        launch(8'h80, 8'h20, 1'b0);
        complete(8'h80, 8'h20, 20, 1'b1);

        // Address wrap on filter and tile
        fill(8'hFC, 8'hF5);
        launch(8'hFC, 8'hF5, 1'b0);
        complete(8'hFC, 8'hF5, 0, 1'b0);

        // Reset during RUN aborts the job
        fill(8'h50, 8'h60);
        launch(8'h50, 8'h60, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        chk("in_run_arr_rst", arr_rst, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_arr_rst", arr_rst, 1'b1);
        chk("abort_valid", bus.res_valid, 1'b0);
        chk("abort_res", bus.res, '0);
        chk("abort_rd_en", bus.mem_rd_en, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 1'b0);
        chk("post_abort_valid", bus.res_valid, 1'b0);
        launch(8'h50, 8'h60, 1'b0);
        complete(8'h50, 8'h60, 0, 1'b0);

        // Back-to-back jobs with start held high
        fill(8'h90, 8'hA0);
        fill(8'hB0, 8'hC0);
        addr_q.delete();
        f_base = 8'h90;
        i_base = 8'hA0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        f_base = 8'hB0;
        i_base = 8'hC0;
        complete(8'h90, 8'hA0, 3, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_relaunch_busy", busy, 1'b1);
        chk("b2b_relaunch_rd", bus.mem_rd_en, 1'b1);
        start = 1'b0;
        complete(8'hB0, 8'hC0, 0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            fb    = 8'($urandom);
            ib    = 8'($urandom);
            hold  = $urandom_range(0, 4);
            early = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            fill(fb, ib);
            launch(fb, ib, early);
            complete(fb, ib, hold, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
